// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-side blocks.
//   - ps2_state_e : transmitter state encoding
//   - PS2_CMD_* / PS2_RSP_ACK : common keyboard command and response bytes
//   - PS2_*_CYCLES / PS2_SYNC_STAGES : default timing at a 50 MHz system clock
//   - ps2_frame() : builds the {stop, odd parity, data} shift frame
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  // 120 us clock inhibit and 20 ms transfer limit at 50 MHz.
  localparam int PS2_INHIBIT_CYCLES = 6000;
  localparam int PS2_TIMEOUT_CYCLES = 1000000;
  localparam int PS2_SYNC_STAGES    = 2;

  // Bit 0 goes out first; the stop bit ends up in bit 9.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS/2 clock and data pin levels into the
// system clock domain and flags falling edges of the synchronised clock.
// Shared between the host transmitter and the receive path.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   clock_in, data_in     raw pin levels
//   clock_sync, data_sync synchronised levels (SYNC_STAGES flops deep)
//   clock_fall            one-cycle pulse: synchronised clock went 1 -> 0
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clock_in,
  input  logic data_in,
  output logic clock_sync,
  output logic data_sync,
  output logic clock_fall
);

  logic [SYNC_STAGES-1:0] clk_pipe_q, clk_pipe_d;
  logic [SYNC_STAGES-1:0] dat_pipe_q, dat_pipe_d;
  logic                   clk_prev_q, clk_prev_d;

  // New samples enter at bit 0; the oldest stage is the synchronised value.
  always_comb begin
    clk_pipe_d = SYNC_STAGES'({clk_pipe_q, clock_in});
    dat_pipe_d = SYNC_STAGES'({dat_pipe_q, data_in});
    clk_prev_d = clk_pipe_q[SYNC_STAGES-1];
  end

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_pipe_q <= '1;
      dat_pipe_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_pipe_q <= clk_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clock_sync = clk_pipe_q[SYNC_STAGES-1];
  assign data_sync  = dat_pipe_q[SYNC_STAGES-1];
  assign clock_fall = clk_prev_q & ~clk_pipe_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter: sends one host-to-device command byte over PS/2.
// Holds the clock low, issues the start bit, shifts data/parity/stop on
// device clock falls, samples the device ACK and waits for the bus to idle.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   tx_data, tx_valid, tx_ready  command byte handshake (accepted only in IDLE)
//   tx_busy                      high whenever a transfer is in progress
//   tx_done, tx_error            one-cycle result pulses
//   ps2_clock_in, ps2_data_in    raw pin levels
//   ps2_clock_oe, ps2_data_oe    1 = pull the pin low, 0 = release
// Optional build macro PS2_TX_RETRY_EN: retry a NACKed or timed-out frame
// up to 3 times before reporting tx_error.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = PS2_SYNC_STAGES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int            IW       = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_END  = IW'(INHIBIT_CYCLES);
  localparam logic [19:0]   TO_LIMIT = 20'(TIMEOUT_CYCLES);

  logic clock_sync, data_sync, clock_fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clock      (clock),
    .reset      (reset),
    .clock_in   (ps2_clock_in),
    .data_in    (ps2_data_in),
    .clock_sync (clock_sync),
    .data_sync  (data_sync),
    .clock_fall (clock_fall)
  );

  ps2_state_e    state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [19:0]   to_cnt_q, to_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_ok_q, ack_ok_d;
  logic          timing, timeout, fail;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]    byte_q, byte_d;
  logic [1:0]    retry_q, retry_d;
`endif

  // State and datapath registers; reset releases both lines on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_oe_q <= 1'b0;
      ack_ok_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      byte_q    <= '0;
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_oe_q <= data_oe_d;
      ack_ok_q  <= ack_ok_d;
`ifdef PS2_TX_RETRY_EN
      byte_q    <= byte_d;
      retry_q   <= retry_d;
`endif
    end
  end

  // Next-state logic. The timeout counter is zero outside SEND/ACK/WAIT_IDLE,
  // so it starts from 0 on the first cycle after the clock line is released.
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_oe_d = data_oe_q;
    ack_ok_d  = ack_ok_q;
    tx_done   = 1'b0;
    tx_error  = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d    = byte_q;
    retry_d   = retry_q;
`endif
    timing   = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
    timeout  = timing && (to_cnt_q == TO_LIMIT);
    to_cnt_d = timing ? to_cnt_q + 20'd1 : '0;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d   = ps2_frame(tx_data);
          inh_cnt_d = '0;
          state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          byte_d    = tx_data;
          retry_d   = '0;
`endif
        end
      end
      // Clock alone is held low for INHIBIT_CYCLES, then one overlap cycle
      // with the start bit before the clock is released in SEND.
      INHIBIT: begin
        if (inh_cnt_q == INH_END) begin
          bit_cnt_d = '0;
          state_d   = SEND;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
          if (inh_cnt_q == INH_LAST) data_oe_d = 1'b1;
        end
      end
      // After nine shifts bit 0 is the stop bit, so fall 10 releases data.
      SEND: begin
        if (clock_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (clock_fall) begin
          ack_ok_d = ~data_sync;
          state_d  = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clock_sync && data_sync) begin
          if (ack_ok_q) begin
            tx_done = 1'b1;
            state_d = IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      tx_done = 1'b0;
      fail    = 1'b1;
    end

    if (fail) begin
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd3) begin
        retry_d   = retry_q + 2'd1;
        shift_d   = ps2_frame(byte_q);
        inh_cnt_d = '0;
        state_d   = INHIBIT;
      end else begin
        tx_error = 1'b1;
        state_d  = IDLE;
      end
`else
      tx_error = 1'b1;
      state_d  = IDLE;
`endif
    end
  end

  assign tx_ready     = (state_q == IDLE);
  assign tx_busy      = (state_q != IDLE);
  assign ps2_clock_oe = (state_q == INHIBIT);
  assign ps2_data_oe  = data_oe_q;

endmodule
